// File: rtl/bsg_clk_gen_pearl_seq.sv
// Bring-up sequencer for an array of clock generators.
//
// A single start_i pulse (accepted only while idle) latches the per-channel
// oscillator, downsampler and select settings plus the dwell count, then walks
// each channel in ascending order through:
//   RESET (W' cycles) -> OSC_LD -> OSC_TRIG -> DS (W' cycles) -> SEL -> MON (W' cycles)
// where W' = max(wait_cycles_i, 1). Each channel costs 3W'+3 cycles.
//
// Ports:
//   clk_i, reset_n_i        clock and asynchronous active-low reset
//   start_i                 sequence request
//   chan_en_i               per-channel enable (latched at start)
//   osc_val_i, ds_val_i     per-channel oscillator / downsampler settings (latched)
//   sel_i                   2-bit clock select per channel (latched)
//   wait_cycles_i           dwell W (latched)
//   async_output_disable_i  combinational override forcing all selects to 2'b11
//   busy_o, done_o          sequence in progress / one-cycle completion pulse
//   async_reset_o, osc_o, osc_trigger_o, ds_o, select_o, monitor_reset_o
//                           registered control outputs to the generator/monitor instances
//
// Build option: BSG_CLK_GEN_PEARL_SEQ_SKIP_EN makes disabled channels cost zero
// cycles. Without it, disabled channels still occupy their slot but none of
// their outputs change.
module bsg_clk_gen_pearl_seq #(
  parameter int unsigned num_chan_p   = 2,
  parameter int unsigned osc_width_p  = 8,
  parameter int unsigned ds_width_p   = 8,
  parameter int unsigned wait_width_p = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              start_i,
  input  logic [num_chan_p-1:0]             chan_en_i,
  input  logic [num_chan_p*osc_width_p-1:0] osc_val_i,
  input  logic [num_chan_p*ds_width_p-1:0]  ds_val_i,
  input  logic [2*num_chan_p-1:0]           sel_i,
  input  logic [wait_width_p-1:0]           wait_cycles_i,
  input  logic                              async_output_disable_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [num_chan_p-1:0]             async_reset_o,
  output logic [num_chan_p*osc_width_p-1:0] osc_o,
  output logic [num_chan_p-1:0]             osc_trigger_o,
  output logic [num_chan_p*ds_width_p-1:0]  ds_o,
  output logic [2*num_chan_p-1:0]           select_o,
  output logic [num_chan_p-1:0]             monitor_reset_o
);

  localparam int unsigned ChanW = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;

  typedef enum logic [2:0] {
    StIdle, StReset, StOscLd, StOscTrig, StDs, StSel, StMon
  } state_e;

  state_e state_q, state_d;
  logic [ChanW-1:0] c_q, c_d;
  logic [wait_width_p-1:0] cnt_q, cnt_d, wait_q, wait_d, dwell_m1;

  // Settings latched at start
  logic [num_chan_p-1:0]             en_q, en_d;
  logic [num_chan_p*osc_width_p-1:0] osc_lat_q, osc_lat_d;
  logic [num_chan_p*ds_width_p-1:0]  ds_lat_q, ds_lat_d;
  logic [2*num_chan_p-1:0]           sel_lat_q, sel_lat_d;

  // Registered outputs
  logic [num_chan_p-1:0]             arst_q, arst_d, trig_q, trig_d, mon_q, mon_d;
  logic [num_chan_p*osc_width_p-1:0] osc_q, osc_d;
  logic [num_chan_p*ds_width_p-1:0]  ds_q, ds_d;
  logic [2*num_chan_p-1:0]           sel_q, sel_d;
  logic                              busy_q, busy_d, done_q, done_d;

  logic             start_acc;
  logic             first_found, next_found;
  logic [ChanW-1:0] first_idx, next_idx;

  assign start_acc = (state_q == StIdle) && start_i;

  always_comb begin
    en_d      = en_q;
    osc_lat_d = osc_lat_q;
    ds_lat_d  = ds_lat_q;
    sel_lat_d = sel_lat_q;
    wait_d    = wait_q;
    if (start_acc) begin
      en_d      = chan_en_i;
      osc_lat_d = osc_val_i;
      ds_lat_d  = ds_val_i;
      sel_lat_d = sel_i;
      wait_d    = wait_cycles_i;
    end
  end

  // W'-1, taken from the value being latched so the first RESET dwell is right
  assign dwell_m1 = (wait_d == '0) ? '0 : wait_d - 1'b1;

  // Channel selection: first channel after start, and successor of c_q
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
`ifdef BSG_CLK_GEN_PEARL_SEQ_SKIP_EN
    // Descending scan so the lowest qualifying index wins
    for (int i = int'(num_chan_p) - 1; i >= 0; i--) begin
      if (chan_en_i[i]) begin
        first_found = 1'b1;
        first_idx   = ChanW'(i);
      end
      if (en_q[i] && (i > int'(c_q))) begin
        next_found = 1'b1;
        next_idx   = ChanW'(i);
      end
    end
`else
    first_found = 1'b1;
    if (int'(c_q) < int'(num_chan_p) - 1) begin
      next_found = 1'b1;
      next_idx   = c_q + 1'b1;
    end
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (first_found) begin
            state_d = StReset;
            c_d     = first_idx;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StReset:   if (cnt_q == '0) state_d = StOscLd;
      StOscLd:   state_d = StOscTrig;
      StOscTrig: state_d = StDs;
      StDs:      if (cnt_q == '0) state_d = StSel;
      StSel:     state_d = StMon;
      StMon: begin
        if (cnt_q == '0) begin
          if (next_found) begin
            state_d = StReset;
            c_d     = next_idx;
          end else begin
            state_d = StIdle;
            c_d     = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Dwell counter: load on entry to a dwell state, count down to zero
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) &&
        ((state_d == StReset) || (state_d == StDs) || (state_d == StMon))) begin
      cnt_d = dwell_m1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Output next values, derived from the upcoming state so outputs are registered
  always_comb begin
    arst_d = arst_q;
    osc_d  = osc_q;
    trig_d = '0;
    ds_d   = ds_q;
    sel_d  = sel_q;
    mon_d  = mon_q;
    busy_d = (state_d != StIdle);
    for (int i = 0; i < int'(num_chan_p); i++) begin
      if (en_d[i] && (int'(c_d) == i)) begin
        if ((state_d == StReset) && (state_q != StReset)) arst_d[i] = 1'b1;
        if (state_d == StOscLd) begin
          arst_d[i] = 1'b0;
          osc_d[i*osc_width_p +: osc_width_p] = osc_lat_q[i*osc_width_p +: osc_width_p];
        end
        if (state_d == StOscTrig) trig_d[i] = 1'b1;
        if ((state_d == StDs) && (state_q != StDs)) begin
          ds_d[i*ds_width_p +: ds_width_p] = ds_lat_q[i*ds_width_p +: ds_width_p];
        end
        if (state_d == StSel) sel_d[2*i +: 2] = sel_lat_q[2*i +: 2];
        if ((state_d == StMon) && (state_q != StMon)) mon_d[i] = 1'b1;
      end
      if (en_q[i] && (int'(c_q) == i) && (state_q == StMon) && (state_d != StMon)) begin
        mon_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= StIdle;
      c_q       <= '0;
      cnt_q     <= '0;
      wait_q    <= '0;
      en_q      <= '0;
      osc_lat_q <= '0;
      ds_lat_q  <= '0;
      sel_lat_q <= '0;
      arst_q    <= '1;
      osc_q     <= '0;
      trig_q    <= '0;
      ds_q      <= '0;
      sel_q     <= '1;
      mon_q     <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      en_q      <= en_d;
      osc_lat_q <= osc_lat_d;
      ds_lat_q  <= ds_lat_d;
      sel_lat_q <= sel_lat_d;
      arst_q    <= arst_d;
      osc_q     <= osc_d;
      trig_q    <= trig_d;
      ds_q      <= ds_d;
      sel_q     <= sel_d;
      mon_q     <= mon_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign async_reset_o   = arst_q;
  assign osc_o           = osc_q;
  assign osc_trigger_o   = trig_q;
  assign ds_o            = ds_q;
  assign monitor_reset_o = mon_q;
  // Override is combinational; sel_q keeps the programmed value underneath
  assign select_o        = async_output_disable_i ? '1 : sel_q;

endmodule
